pc_fetch_unit: RTL and testbench
================================

Name: pc_fetch_unit

Overview:
Program-counter register and instruction-fetch sequencer, directly downstream of the 5-to-1 next-PC mux. Latches the selected next PC, issues a request/acknowledge read to instruction memory, and holds the fetched instruction with a valid flag for the decode stage. Supports decode stalls, redirect flushes, alignment checking and a fetch timeout.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
TIMEOUT, 16, max cycles in FETCH without imem_ack before timeout_err (legal 2..255)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous active-low reset
pc_mux  in  32  next PC from the upstream next-PC mux
stall  in  1  decode stage cannot accept; hold current instruction
flush  in  1  redirect: discard current fetch/instruction, load pc_mux
imem_req  out  1  instruction memory read request
imem_addr  out  32  read address (always equals pc)
imem_ack  in  1  memory returns data this cycle
imem_rdata  in  32  instruction word, valid when imem_ack=1
pc  out  32  address of the instruction being fetched or held
pc_plus4  out  32  pc+4, combinational, fed back to the next-PC mux
inst  out  32  fetched instruction
inst_valid  out  1  inst is valid for decode
align_err  out  1  one-cycle pulse: pc_mux[1:0]!=0 when loaded
timeout_err  out  1  one-cycle pulse: fetch timed out

Behaviour:
- All state updates occur on the rising clk edge; rst_n is sampled only there.
- Reset (rst_n=0): pc=RESET_PC, inst=0, inst_valid=0, imem_req=0, align_err=0, timeout_err=0, wait counter=0, state=BOOT. Reset asserted mid-fetch abandons the fetch; a late imem_ack is ignored.
- States: BOOT, FETCH, VALID.
- BOOT: imem_req=0. Next cycle goes to FETCH. pc is unchanged.
- FETCH: imem_req=1, imem_addr=pc, and the wait counter increments each cycle.
  - imem_ack=1: inst<=imem_rdata, inst_valid<=1, counter<=0, go to VALID. Fetch latency is therefore one cycle after ack.
  - No ack for TIMEOUT consecutive cycles: timeout_err pulses one cycle, counter<=0, stay in FETCH with imem_req held (re-issue).
- VALID: imem_req=0, inst_valid=1.
  - stall=1: hold pc, inst and state.
  - stall=0: pc<=pc_mux, inst_valid<=0, go to FETCH. At most one instruction every 2 cycles with zero-wait memory.
- flush=1 in any non-reset state takes priority over stall and imem_ack:
  - pc<=pc_mux, inst_valid<=0, counter<=0, go to FETCH.
  - Data acked in the same cycle is discarded.
- PC load rule (both the VALID advance and flush): pc<={pc_mux[31:2],2'b00}. If pc_mux[1:0]!=0, align_err pulses in the following cycle.
- pc_plus4 wraps modulo 2^32; for example, 32'hFFFF_FFFC gives 32'h0000_0000.
- align_err and timeout_err are pulses that default to 0 each cycle.
- inst retains its last value while inst_valid=0; inst is cleared only by reset.

Test Plan:
- Reset then run: RESET_PC=0, ack one cycle after each req, stall=0, pc_mux=pc_plus4 → pc sequence 0,4,8,C; inst_valid high every 2nd cycle; inst matches memory words.
- Stall hold: in VALID with inst=32'h2408_0005, hold stall=1 for 3 cycles → pc, inst and inst_valid=1 unchanged, imem_req=0; stall=0 → pc advances to 4.
- Flush with same-cycle ack: in FETCH at pc=8, flush=1, imem_ack=1, pc_mux=32'h0000_0100 → inst_valid stays 0, pc=0x100, imem_req=1 next cycle, old data never presented.
- Misaligned target: flush with pc_mux=32'h0000_0206 → pc=0x204, align_err pulses exactly once.
- Timeout: TIMEOUT=4, never ack → timeout_err pulses after 4 FETCH cycles and every 4 thereafter; imem_req stays 1; a later ack yields inst_valid=1.
- Reset mid-fetch and wrap: rst_n=0 during FETCH → next cycle pc=RESET_PC and imem_req=0; separately, pc=32'hFFFF_FFFC → pc_plus4=0.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - program counter register and instruction fetch sequencer
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc_mux,
    input  logic        stall,
    input  logic        flush,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] inst,
    output logic        inst_valid,
    output logic        align_err,
    output logic        timeout_err
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        VALID = 2'd2
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state;
    state_t      state_nxt;
    logic [31:0] pc_nxt;
    logic [31:0] inst_nxt;
    logic [7:0]  cnt;
    logic [7:0]  cnt_nxt;
    logic        align_nxt;
    logic        tout_nxt;
    logic [31:0] pc_load;
    logic        pc_load_bad;

    // Targets are forced to word alignment; the low bits only raise align_err.
    assign pc_load     = {pc_mux[31:2], 2'b00};
    assign pc_load_bad = |pc_mux[1:0];

    assign imem_req   = (state == FETCH);
    assign inst_valid = (state == VALID);
    assign imem_addr  = pc;
    assign pc_plus4   = pc + 32'd4;

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        inst_nxt  = inst;
        cnt_nxt   = cnt;
        align_nxt = 1'b0;
        tout_nxt  = 1'b0;
        if (flush) begin
            // Redirect wins over stall and over data acked this same cycle.
            pc_nxt    = pc_load;
            align_nxt = pc_load_bad;
            cnt_nxt   = 8'd0;
            state_nxt = FETCH;
        end else begin
            case (state)
                BOOT: begin
                    cnt_nxt   = 8'd0;
                    state_nxt = FETCH;
                end
                FETCH: begin
                    if (imem_ack) begin
                        inst_nxt  = imem_rdata;
                        cnt_nxt   = 8'd0;
                        state_nxt = VALID;
                    end else if (cnt == CNT_LAST) begin
                        // Request stays up; the same address is simply re-issued.
                        tout_nxt = 1'b1;
                        cnt_nxt  = 8'd0;
                    end else begin
                        cnt_nxt = cnt + 8'd1;
                    end
                end
                VALID: begin
                    if (!stall) begin
                        pc_nxt    = pc_load;
                        align_nxt = pc_load_bad;
                        cnt_nxt   = 8'd0;
                        state_nxt = FETCH;
                    end
                end
                default: begin
                    state_nxt = BOOT;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= BOOT;
            pc          <= RESET_PC;
            inst        <= 32'd0;
            cnt         <= 8'd0;
            align_err   <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            inst        <= inst_nxt;
            cnt         <= cnt_nxt;
            align_err   <= align_nxt;
            timeout_err <= tout_nxt;
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - randomized and directed bench for pc_fetch_unit
module tb_pc_fetch_unit;

    localparam int          TO   = 4;
    localparam logic [31:0] RPC  = 32'h0000_0000;

    logic        clk;
    logic        rst_n;
    logic [31:0] pc_mux;
    logic        stall;
    logic        flush;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] inst;
    logic        inst_valid;
    logic        align_err;
    logic        timeout_err;

    int tests = 0;
    int fails = 0;

    pc_fetch_unit #(.RESET_PC(RPC), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .pc_mux(pc_mux), .stall(stall), .flush(flush),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .pc(pc), .pc_plus4(pc_plus4), .inst(inst),
        .inst_valid(inst_valid), .align_err(align_err), .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: what the fetch unit is doing, kept as plain flags and counts.
    logic [31:0] m_pc = RPC;
    logic [31:0] m_inst = 32'd0;
    bit          m_valid = 1'b0;
    bit          m_fetching = 1'b0;
    bit          m_booting = 1'b1;
    int          m_wait = 0;
    bit          m_align = 1'b0;
    bit          m_tout = 1'b0;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        m_align = 1'b0;
        m_tout  = 1'b0;
        if (!rst_n) begin
            m_pc = RPC; m_inst = 32'd0; m_valid = 1'b0;
            m_fetching = 1'b0; m_booting = 1'b1; m_wait = 0;
        end else if (flush) begin
            m_pc = pc_mux & 32'hFFFF_FFFC;
            m_align = (pc_mux % 4) != 0;
            m_valid = 1'b0; m_fetching = 1'b1; m_booting = 1'b0; m_wait = 0;
        end else if (m_booting) begin
            m_booting = 1'b0; m_fetching = 1'b1; m_wait = 0;
        end else if (m_fetching) begin
            if (imem_ack) begin
                m_inst = imem_rdata; m_valid = 1'b1; m_fetching = 1'b0; m_wait = 0;
            end else begin
                m_wait++;
                if (m_wait == TO) begin
                    m_tout = 1'b1;
                    m_wait = 0;
                end
            end
        end else if (!stall) begin
            m_pc = pc_mux & 32'hFFFF_FFFC;
            m_align = (pc_mux % 4) != 0;
            m_valid = 1'b0; m_fetching = 1'b1;
        end
    end

    always @(negedge clk) begin
        chk("pc", pc, m_pc);
        chk("pc_plus4", pc_plus4, m_pc + 32'd4);
        chk("imem_addr", imem_addr, m_pc);
        chk("imem_req", {31'd0, imem_req}, {31'd0, m_fetching});
        chk("inst_valid", {31'd0, inst_valid}, {31'd0, m_valid});
        chk("inst", inst, m_inst);
        chk("align_err", {31'd0, align_err}, {31'd0, m_align});
        chk("timeout_err", {31'd0, timeout_err}, {31'd0, m_tout});
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] seen_pc[$];
    logic [31:0] seen_inst[$];
    logic [12:0] tmask;
    int          align_cnt;
    int          req_low;

    initial begin
        rst_n = 1'b0; pc_mux = 32'd0; stall = 1'b0; flush = 1'b0;
        imem_ack = 1'b0; imem_rdata = 32'd0;
        repeat (3) cyc();
        chk("rst_pc", pc, 32'h0000_0000);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_valid", {31'd0, inst_valid}, 32'd0);
        chk("rst_inst", inst, 32'd0);

        // Zero-wait run with sequential next PC.
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            imem_ack   = m_fetching;
            imem_rdata = mem(m_pc);
            pc_mux     = m_pc + 32'd4;
            cyc();
            if (inst_valid) begin
                seen_pc.push_back(pc);
                seen_inst.push_back(inst);
            end
        end
        chk("run_count", seen_pc.size(), 32'd6);
        if (seen_pc.size() >= 4) begin
            chk("run_pc0", seen_pc[0], 32'h0000_0000);
            chk("run_pc1", seen_pc[1], 32'h0000_0004);
            chk("run_pc2", seen_pc[2], 32'h0000_0008);
            chk("run_pc3", seen_pc[3], 32'h0000_000C);
            chk("run_inst0", seen_inst[0], 32'hFFFF_0000);
            chk("run_inst3", seen_inst[3], 32'hFFF3_000C);
        end

        // Stall hold.
        imem_ack = 1'b0;
        rst_n = 1'b0; cyc();
        rst_n = 1'b1; cyc();
        imem_ack = 1'b1; imem_rdata = 32'h2408_0005; cyc();
        imem_ack = 1'b0; stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("stall_pc", pc, 32'h0000_0000);
            chk("stall_inst", inst, 32'h2408_0005);
            chk("stall_valid", {31'd0, inst_valid}, 32'd1);
            chk("stall_req", {31'd0, imem_req}, 32'd0);
        end
        stall = 1'b0; pc_mux = 32'h0000_0004; cyc();
        chk("unstall_pc", pc, 32'h0000_0004);
        chk("unstall_req", {31'd0, imem_req}, 32'd1);

        // Flush racing an ack.
        imem_ack = 1'b1; imem_rdata = mem(32'h4); cyc();
        imem_ack = 1'b0; pc_mux = 32'h0000_0008; cyc();
        chk("pre_flush_pc", pc, 32'h0000_0008);
        flush = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF; pc_mux = 32'h0000_0100; cyc();
        chk("flush_pc", pc, 32'h0000_0100);
        chk("flush_valid", {31'd0, inst_valid}, 32'd0);
        chk("flush_req", {31'd0, imem_req}, 32'd1);
        chk("flush_inst", inst, 32'hFFFB_0004);

        // Misaligned redirect then timeout.
        imem_ack = 1'b0; pc_mux = 32'h0000_0206; cyc();
        chk("mis_pc", pc, 32'h0000_0204);
        chk("mis_align", {31'd0, align_err}, 32'd1);
        flush = 1'b0;
        tmask = 13'd0; align_cnt = 0; req_low = 0;
        for (int i = 1; i <= 12; i++) begin
            cyc();
            if (timeout_err) tmask[i] = 1'b1;
            if (align_err) align_cnt++;
            if (!imem_req) req_low++;
        end
        chk("tout_mask", {19'd0, tmask}, 32'h0000_1110);
        chk("tout_align", align_cnt, 32'd0);
        chk("tout_req", req_low, 32'd0);
        imem_ack = 1'b1; imem_rdata = 32'h1234_5678; cyc();
        chk("late_valid", {31'd0, inst_valid}, 32'd1);
        chk("late_inst", inst, 32'h1234_5678);

        // Reset mid-fetch with ack.
        imem_ack = 1'b0; pc_mux = 32'h0000_0208; cyc();
        rst_n = 1'b0; imem_ack = 1'b1; cyc();
        chk("mrst_pc", pc, RPC);
        chk("mrst_req", {31'd0, imem_req}, 32'd0);
        chk("mrst_valid", {31'd0, inst_valid}, 32'd0);

        // Wraparound.
        rst_n = 1'b1; imem_ack = 1'b0; cyc();
        flush = 1'b1; pc_mux = 32'hFFFF_FFFC; cyc();
        chk("wrap_pc", pc, 32'hFFFF_FFFC);
        chk("wrap_plus4", pc_plus4, 32'h0000_0000);
        flush = 1'b0;

        for (int i = 0; i < 3000; i++) begin
            rst_n      = ($urandom_range(0, 199) != 0);
            flush      = ($urandom_range(0, 9) == 0);
            stall      = $urandom_range(0, 1) != 0;
            imem_ack   = ($urandom_range(0, 2) == 0);
            imem_rdata = $urandom;
            pc_mux     = ($urandom_range(0, 7) == 0) ? $urandom : (m_pc + 32'd4);
            cyc();
        end

        @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
